sigmoid_pwl_pipe: RTL



---
 rtl/sigmoid_pwl_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sigmoid_pwl_pipe.sv
// sigmoid_pwl_pipe: 3-stage piecewise-linear sigmoid
// with valid/ready on both sides and bubble collapsing.
module sigmoid_pwl_pipe #(
  parameter int IN_W    = 8,
  parameter int FRAC_IN = 4,
  parameter logic [(2**(IN_W-1-FRAC_IN)+1)*16-1:0] Y_TAB = {
    16'hFFEA, 16'hFFC4, 16'hFF5E,
    16'hFE49, 16'hFB65, 16'hF3DC,
    16'hE17C, 16'hBB27, 16'h8000
  },
  parameter logic [(2**(IN_W-1-FRAC_IN))*16-1:0] D_TAB = {
    16'd38,   16'd102,  16'd277,
    16'd740,  16'd1929, 16'd4704,
    16'd9813, 16'd15143
  }
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [IN_W-1:0] i_x,
  output logic [15:0]     o_y,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [50:0]     number
);

  localparam int KW  = IN_W - 1 - FRAC_IN;
  localparam int SEG = 2 ** KW;
  localparam int PW  = 16 + FRAC_IN;

  localparam logic [15:0] Y_TOP =
    Y_TAB[SEG*16 +: 16];

  // Transistor cost per cell type.
  localparam int T_DFF = 28;
  localparam int T_FA  = 28;
  localparam int T_HA  = 14;
  localparam int T_XOR = 12;
  localparam int T_MUX = 12;
  localparam int T_AND = 6;

  // Register bits: S1, S2, S3 payloads plus 3 valids.
  localparam int N_FF =
    (2 + KW + FRAC_IN) +
    (2 + KW + 16) +
    16 + 3;

  localparam int N_TR =
    N_FF * T_DFF +
    IN_W * (T_XOR + T_HA) +
    16 * (SEG - 1) * T_MUX +
    16 * SEG * T_MUX +
    16 * FRAC_IN * T_AND +
    (FRAC_IN - 1) * PW * T_FA +
    16 * T_FA +
    16 * T_MUX +
    16 * (T_XOR + T_HA) +
    16 * T_MUX +
    4 * T_AND;

  assign number = 51'(N_TR);

  // Knot and slope tables unpacked for
  // direct indexing by segment number.
  logic [15:0] y_knot  [SEG];
  logic [15:0] d_slope [SEG];

  for (genvar g = 0; g < SEG; g++) begin : g_tab
    assign y_knot[g]  = Y_TAB[g*16 +: 16];
    assign d_slope[g] = D_TAB[g*16 +: 16];
  end

  // Stage registers.
  logic              s1_vld_q;
  logic              s1_neg_q, s1_neg_d;
  logic              s1_sat_q, s1_sat_d;
  logic [KW-1:0]     s1_k_q,   s1_k_d;
  logic [FRAC_IN-1:0] s1_f_q,  s1_f_d;

  logic              s2_vld_q;
  logic              s2_neg_q;
  logic              s2_sat_q;
  logic [KW-1:0]     s2_k_q;
  logic [15:0]       s2_p_q,   s2_p_d;

  logic              s3_vld_q;
  logic [15:0]       s3_y_q,   s3_y_d;

  // Load enables ripple back from the output.
  logic out_xfer;
  logic ld1, ld2, ld3;

  assign out_xfer = s3_vld_q & i_out_ready;
  assign ld3 = ~s3_vld_q | out_xfer;
  assign ld2 = ~s2_vld_q | ld3;
  assign ld1 = ~s1_vld_q | ld2;

  assign o_in_ready  = ld1;
  assign o_out_valid = s3_vld_q;
  assign o_y         = s3_y_q;

  // S1: fold sign, split |x| into segment
  // and fraction; -2^(IN_W-1) saturates.
  logic [IN_W-1:0] x_abs;

  always_comb begin
    s1_neg_d = i_x[IN_W-1];
    x_abs    = s1_neg_d ? -i_x : i_x;
    s1_sat_d = x_abs[IN_W-1];
    s1_k_d   = x_abs[IN_W-2:FRAC_IN];
    s1_f_d   = x_abs[FRAC_IN-1:0];
  end

  // S1 register: capture on input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_neg_q <= 1'b0;
      s1_sat_q <= 1'b0;
      s1_k_q   <= '0;
      s1_f_q   <= '0;
    end else begin
      if (ld1) s1_vld_q <= i_in_valid;
      if (ld1 && i_in_valid) begin
        s1_neg_q <= s1_neg_d;
        s1_sat_q <= s1_sat_d;
        s1_k_q   <= s1_k_d;
        s1_f_q   <= s1_f_d;
      end
    end
  end

  // S2: slope times fraction, truncated.
  logic [PW-1:0] prod;

  always_comb begin
    prod = {{FRAC_IN{1'b0}}, d_slope[s1_k_q]} *
           {16'b0, s1_f_q};
    s2_p_d = 16'(prod >> FRAC_IN);
  end

  // S2 register: advance when S3 can take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_neg_q <= 1'b0;
      s2_sat_q <= 1'b0;
      s2_k_q   <= '0;
      s2_p_q   <= '0;
    end else begin
      if (ld2) s2_vld_q <= s1_vld_q;
      if (ld2 && s1_vld_q) begin
        s2_neg_q <= s1_neg_q;
        s2_sat_q <= s1_sat_q;
        s2_k_q   <= s1_k_q;
        s2_p_q   <= s2_p_d;
      end
    end
  end

  // S3: knot plus offset, mirrored for x < 0.
  logic [15:0] yp;

  always_comb begin
    yp = s2_sat_q ? Y_TOP
                  : y_knot[s2_k_q] + s2_p_q;
    s3_y_d = s2_neg_q ? (~yp + 16'd1) : yp;
  end

  // S3 register: holds o_y until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_vld_q <= 1'b0;
      s3_y_q   <= '0;
    end else begin
      if (ld3) s3_vld_q <= s2_vld_q;
      if (ld3 && s2_vld_q) s3_y_q <= s3_y_d;
    end
  end

endmodule
